i2d_ifq: RTL and testbench

//  Instruction fetch queue between the fetch stage and decode. Buffers up to DEPTH
//  {instruction, pc, err} entries produced by fetch and presents them in order to decode.

---
 rtl/i2d_ifq.sv | 135 +++++++++++++
 tb/tb_i2d_ifq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2d_ifq.sv
// +----------------------------------------------------------------------------+
// | Module      : i2d_ifq                                                        |
// | Description : Instruction fetch queue between fetch and decode. Buffers    |
// |               {err, pc, ins} beats, presents the oldest one show-ahead to  |
// |               decode and produces the fetch advance enable (if_dis).       |
// | Config      : define I2D_IFQ_BYPASS_EN to let a beat arriving at an empty  |
// |               queue reach decode in the same cycle.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef I2D_INS_NOP
`define I2D_INS_NOP 6'b010101
`endif

module i2d_ifq #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   if_ins,
   input  logic [31:0]   if_pc,
   input  logic          if_valid,
   input  logic          if_err,
   output logic          if_dis,
   input  logic          flush,
   output logic [31:0]   id_ins,
   output logic [31:0]   id_pc,
   output logic          id_valid,
   output logic          id_err,
   input  logic          id_ready,
   output logic [AW:0]   ifq_cnt
);

   localparam logic [AW:0]  c_full   = (AW+1)'(DEPTH);
   localparam logic [31:0]  c_nop    = {`I2D_INS_NOP, 26'b0};

   // Entry layout: {err, pc[31:0], ins[31:0]}
   logic [64:0]    r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_cnt;
   logic           r_err_hold;

   logic           w_push;
   logic           w_pop;
   logic           w_write;
   logic           w_rd_adv;
   logic           w_bypass;
   logic           w_head_valid;
   logic [64:0]    w_head;

   // Fetch may advance only when a slot is free, no error is pending and no
   // redirect is in progress. A full queue never accepts, even if decode pops
   // in the same cycle, so the enable does not depend on id_ready.
   assign if_dis = rst & (r_cnt != c_full) & ~r_err_hold & ~flush;

   assign w_push       = if_valid & if_dis & ~flush;
   assign w_head_valid = (r_cnt != '0);
   assign w_head       = r_mem[r_rd_ptr];

`ifdef I2D_IFQ_BYPASS_EN
   // A beat arriving at an empty queue is shown to decode directly; if decode
   // takes it in the same cycle it never occupies storage.
   assign w_bypass = w_push & ~w_head_valid;
   assign w_write  = w_push & ~(w_bypass & id_ready);
   assign w_rd_adv = w_pop & ~w_bypass;
`else
   assign w_bypass = 1'b0;
   assign w_write  = w_push;
   assign w_rd_adv = w_pop;
`endif

   assign id_valid = w_head_valid | w_bypass;
   assign w_pop    = id_valid & id_ready & ~flush;
   assign ifq_cnt  = r_cnt;

   // Decode-side view: stored head, bypassed fetch beat, or an idle NOP
   always_comb begin
      id_ins = c_nop;
      id_pc  = 32'h0;
      id_err = 1'b0;
      if (w_head_valid) begin
         id_ins = w_head[31:0];
         id_pc  = w_head[63:32];
         id_err = w_head[64];
      end else if (w_bypass) begin
         id_ins = if_ins;
         id_pc  = if_pc;
         id_err = if_err;
      end
   end

   // Entry storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= {if_err, if_pc, if_ins};
      end
   end

   // Pointer, occupancy and error-stall bookkeeping; flush restarts the queue
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_err_hold <= 1'b0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_err_hold <= 1'b0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_adv) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_write && !w_rd_adv) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!w_write && w_rd_adv) begin
            r_cnt <= r_cnt - 1'b1;
         end
         // An erroneous beat stalls fetch until the next redirect
         if (w_push && if_err) begin
            r_err_hold <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2d_ifq.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_i2d_ifq                                                     |
// | Description : Directed self-checking bench for the instruction fetch queue.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef I2D_INS_NOP
`define I2D_INS_NOP 6'b010101
`endif

module tb_i2d_ifq;

   localparam logic [31:0] c_nop = {`I2D_INS_NOP, 26'b0};

   logic        clk;
   logic        rst;
   logic [31:0] if_ins;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        if_err;
   logic        if_dis;
   logic        flush;
   logic [31:0] id_ins;
   logic [31:0] id_pc;
   logic        id_valid;
   logic        id_err;
   logic        id_ready;
   logic [2:0]  ifq_cnt;

   int n_cmp;
   int n_bad;

   i2d_ifq #(.DEPTH(4), .AW(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .if_ins   (if_ins),
      .if_pc    (if_pc),
      .if_valid (if_valid),
      .if_err   (if_err),
      .if_dis   (if_dis),
      .flush    (flush),
      .id_ins   (id_ins),
      .id_pc    (id_pc),
      .id_valid (id_valid),
      .id_err   (id_err),
      .id_ready (id_ready),
      .ifq_cnt  (ifq_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs change here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Move to mid-cycle where outputs are sampled
   task automatic settle();
      #4;
   endtask

   task automatic beat(input logic [31:0] pc, input logic err);
      if_valid = 1'b1;
      if_pc    = pc;
      if_ins   = 32'hA000_0000 | pc;
      if_err   = err;
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      flush    = $urandom_range(0, 1);
      if_valid = $urandom_range(0, 1);
      if_err   = $urandom_range(0, 1);
      id_ready = $urandom_range(0, 1);
      if_pc    = $urandom;
      if_ins   = $urandom;
      tick(); tick(); settle();
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
      n_cmp++; if (id_ins !== c_nop) begin n_bad++; $display("FAIL reset_id_ins got %h want %h", id_ins, c_nop); end
      n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_id_pc got %h want 0", id_pc); end
      n_cmp++; if (id_err !== 1'b0) begin n_bad++; $display("FAIL reset_id_err got %b want 0", id_err); end
      n_cmp++; if (if_dis !== 1'b0) begin n_bad++; $display("FAIL reset_if_dis got %b want 0", if_dis); end
      n_cmp++; if (ifq_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", ifq_cnt); end
      flush = 1'b0; if_valid = 1'b0; if_err = 1'b0; id_ready = 1'b0;
      #1;
      rst = 1'b1;
      tick(); settle();
      n_cmp++; if (if_dis !== 1'b1) begin n_bad++; $display("FAIL release_if_dis got %b want 1", if_dis); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL release_id_valid got %b want 0", id_valid); end
   endtask

   task automatic test_fill_drain();
      tick();
      for (int i = 0; i < 4; i++) begin
         beat(32'(4 * i), 1'b0);
         settle();
         n_cmp++; if (if_dis !== 1'b1) begin n_bad++; $display("FAIL fill_if_dis beat %0d got %b want 1", i, if_dis); end
         tick();
      end
      beat(32'h10, 1'b0);
      settle();
      n_cmp++; if (if_dis !== 1'b0) begin n_bad++; $display("FAIL full_if_dis got %b want 0", if_dis); end
      n_cmp++; if (ifq_cnt !== 3'd4) begin n_bad++; $display("FAIL full_cnt got %0d want 4", ifq_cnt); end
      n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL full_head_pc got %h want 0", id_pc); end
      n_cmp++; if (id_ins !== 32'hA000_0000) begin n_bad++; $display("FAIL full_head_ins got %h want a0000000", id_ins); end
      // Pop while full: still no acceptance this cycle
      tick(); id_ready = 1'b1; settle();
      n_cmp++; if (if_dis !== 1'b0) begin n_bad++; $display("FAIL full_pop_if_dis got %b want 0", if_dis); end
      n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL drain_pc0 got %h want 0", id_pc); end
      // One slot freed: fifth beat re-presented and accepted alongside a pop
      tick(); settle();
      n_cmp++; if (if_dis !== 1'b1) begin n_bad++; $display("FAIL refill_if_dis got %b want 1", if_dis); end
      n_cmp++; if (id_pc !== 32'h4) begin n_bad++; $display("FAIL drain_pc4 got %h want 4", id_pc); end
      n_cmp++; if (ifq_cnt !== 3'd3) begin n_bad++; $display("FAIL drain_cnt3 got %0d want 3", ifq_cnt); end
      tick(); if_valid = 1'b0; settle();
      n_cmp++; if (id_pc !== 32'h8) begin n_bad++; $display("FAIL drain_pc8 got %h want 8", id_pc); end
      n_cmp++; if (ifq_cnt !== 3'd3) begin n_bad++; $display("FAIL drain_cnt_pp got %0d want 3", ifq_cnt); end
      tick(); settle();
      n_cmp++; if (id_pc !== 32'hC) begin n_bad++; $display("FAIL drain_pcC got %h want c", id_pc); end
      tick(); settle();
      n_cmp++; if (id_pc !== 32'h10) begin n_bad++; $display("FAIL drain_pc10 got %h want 10", id_pc); end
      tick(); settle();
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got %b want 0", id_valid); end
      n_cmp++; if (ifq_cnt !== 3'd0) begin n_bad++; $display("FAIL drain_cnt0 got %0d want 0", ifq_cnt); end
      n_cmp++; if (id_ins !== c_nop) begin n_bad++; $display("FAIL drain_nop got %h want %h", id_ins, c_nop); end
      tick(); id_ready = 1'b0;
   endtask

   task automatic test_push_pop();
      beat(32'h100, 1'b0); tick();
      beat(32'h104, 1'b0); tick();
      id_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         beat(32'h108 + 32'(4 * i), 1'b0);
         settle();
         n_cmp++; if (ifq_cnt !== 3'd2) begin n_bad++; $display("FAIL pp_cnt cycle %0d got %0d want 2", i, ifq_cnt); end
         n_cmp++; if (id_pc !== 32'h100 + 32'(4 * i)) begin n_bad++; $display("FAIL pp_pc cycle %0d got %h want %h", i, id_pc, 32'h100 + 32'(4 * i)); end
         tick();
      end
      if_valid = 1'b0; settle();
      n_cmp++; if (id_pc !== 32'h128) begin n_bad++; $display("FAIL pp_tail0 got %h want 128", id_pc); end
      tick(); settle();
      n_cmp++; if (id_pc !== 32'h12C) begin n_bad++; $display("FAIL pp_tail1 got %h want 12c", id_pc); end
      tick(); settle();
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL pp_empty got %b want 0", id_valid); end
      tick(); id_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         beat(32'h200 + 32'(4 * i), 1'b0); tick();
      end
      beat(32'h20C, 1'b0);
      flush = 1'b1; id_ready = 1'b1;
      settle();
      n_cmp++; if (if_dis !== 1'b0) begin n_bad++; $display("FAIL flush_if_dis got %b want 0", if_dis); end
      n_cmp++; if (ifq_cnt !== 3'd3) begin n_bad++; $display("FAIL flush_cnt_before got %0d want 3", ifq_cnt); end
      tick(); flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0; settle();
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL flush_id_valid got %b want 0", id_valid); end
      n_cmp++; if (ifq_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_cnt got %0d want 0", ifq_cnt); end
      n_cmp++; if (if_dis !== 1'b1) begin n_bad++; $display("FAIL flush_after_if_dis got %b want 1", if_dis); end
      tick(); beat(32'h300, 1'b0); tick(); if_valid = 1'b0; settle();
      n_cmp++; if (id_pc !== 32'h300) begin n_bad++; $display("FAIL flush_restart_pc got %h want 300", id_pc); end
      n_cmp++; if (ifq_cnt !== 3'd1) begin n_bad++; $display("FAIL flush_restart_cnt got %0d want 1", ifq_cnt); end
      tick(); id_ready = 1'b1; tick(); id_ready = 1'b0;
   endtask

   task automatic test_error();
      beat(32'h20, 1'b1); tick();
      beat(32'h24, 1'b0); settle();
      n_cmp++; if (if_dis !== 1'b0) begin n_bad++; $display("FAIL err_if_dis got %b want 0", if_dis); end
      n_cmp++; if (id_err !== 1'b1) begin n_bad++; $display("FAIL err_id_err got %b want 1", id_err); end
      n_cmp++; if (id_pc !== 32'h20) begin n_bad++; $display("FAIL err_id_pc got %h want 20", id_pc); end
      n_cmp++; if (ifq_cnt !== 3'd1) begin n_bad++; $display("FAIL err_cnt got %0d want 1", ifq_cnt); end
      tick(); id_ready = 1'b1; tick(); id_ready = 1'b0; tick(); tick(); settle();
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL err_drained got %b want 0", id_valid); end
      n_cmp++; if (if_dis !== 1'b0) begin n_bad++; $display("FAIL err_stall_held got %b want 0", if_dis); end
      tick(); flush = 1'b1; tick(); flush = 1'b0; if_valid = 1'b0; settle();
      n_cmp++; if (if_dis !== 1'b1) begin n_bad++; $display("FAIL err_cleared got %b want 1", if_dis); end
      tick();
   endtask

   task automatic test_bypass();
      beat(32'h40, 1'b0); id_ready = 1'b1; settle();
`ifdef I2D_IFQ_BYPASS_EN
      n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL byp_valid got %b want 1", id_valid); end
      n_cmp++; if (id_pc !== 32'h40) begin n_bad++; $display("FAIL byp_pc got %h want 40", id_pc); end
      tick(); if_valid = 1'b0; id_ready = 1'b0; settle();
      n_cmp++; if (ifq_cnt !== 3'd0) begin n_bad++; $display("FAIL byp_cnt got %0d want 0", ifq_cnt); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL byp_after got %b want 0", id_valid); end
`else
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL nobyp_valid got %b want 0", id_valid); end
      tick(); if_valid = 1'b0; id_ready = 1'b0; settle();
      n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL nobyp_next_valid got %b want 1", id_valid); end
      n_cmp++; if (id_pc !== 32'h40) begin n_bad++; $display("FAIL nobyp_pc got %h want 40", id_pc); end
      n_cmp++; if (ifq_cnt !== 3'd1) begin n_bad++; $display("FAIL nobyp_cnt got %0d want 1", ifq_cnt); end
      tick(); id_ready = 1'b1; tick(); id_ready = 1'b0;
`endif
      tick();
   endtask

   task automatic test_reset_mid();
      beat(32'h500, 1'b0); tick();
      beat(32'h504, 1'b0); tick();
      if_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (ifq_cnt !== 3'd0) begin n_bad++; $display("FAIL rmid_cnt got %0d want 0", ifq_cnt); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", id_valid); end
      n_cmp++; if (if_dis !== 1'b0) begin n_bad++; $display("FAIL rmid_if_dis got %b want 0", if_dis); end
      n_cmp++; if (id_ins !== c_nop) begin n_bad++; $display("FAIL rmid_ins got %h want %h", id_ins, c_nop); end
      tick(); rst = 1'b1; settle();
      n_cmp++; if (if_dis !== 1'b1) begin n_bad++; $display("FAIL rmid_release got %b want 1", if_dis); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_lost got %b want 0", id_valid); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_fill_drain();
      test_push_pop();
      test_flush();
      test_error();
      test_bypass();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
